// File: rtl/seg_pkg.sv
// Shared types and constants for the seven-segment readout.
// Glyphs are active-low, bit order gfedcba.
package seg_pkg;

   typedef enum logic [1:0] {
      IDLE,
      CONV,
      DONE
   } state_t;

   localparam logic [6:0] SEG_BLANK = 7'h7F;
   localparam logic [6:0] SEG_DASH  = 7'h3F;

   // Entry 0 in the low bits, entry F in the high bits.
   localparam logic [16*7-1:0] HEX_GLYPHS = {
      7'h0E, 7'h06, 7'h21, 7'h46,
      7'h03, 7'h08, 7'h10, 7'h00,
      7'h78, 7'h02, 7'h12, 7'h19,
      7'h30, 7'h24, 7'h79, 7'h40
   };

   function automatic logic [6:0] hex_glyph(input logic [3:0] n);
      return HEX_GLYPHS[7*int'(n) +: 7];
   endfunction

   // ceil(w*log10(2) + 1) decimal digits
   function automatic int bcd_digits(input int w);
      return (w * 30103 + 199_999) / 100_000;
   endfunction

endpackage

// File: rtl/btn_debouncer.sv
// Two-flop synchroniser plus stability counter for an active-low key.
// press pulses for one cycle when the debounced level falls.
module btn_debouncer
   import seg_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 500_000
) (
   input  logic clk,
   input  logic reset,
   input  logic btn_n,
   output logic press
);

   localparam int CNT_W =
      (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam logic [CNT_W-1:0] CNT_MAX =
      CNT_W'(DEBOUNCE_CYCLES - 1);

   logic             sync1_q;
   logic             sync2_q;
   logic             level_q;
   logic [CNT_W-1:0] cnt_q;
   logic             flip;

   assign flip  = (sync2_q != level_q) && (cnt_q == CNT_MAX);
   assign press = flip && level_q;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         sync1_q <= 1'b1;
         sync2_q <= 1'b1;
         level_q <= 1'b1;
         cnt_q   <= '0;
      end else begin
         sync1_q <= btn_n;
         sync2_q <= sync1_q;
         if (sync2_q == level_q) begin
            cnt_q <= '0;
         end else if (flip) begin
            level_q <= sync2_q;
            cnt_q   <= '0;
         end else begin
            cnt_q <= cnt_q + 1'b1;
         end
      end
   end

endmodule

// File: rtl/seg_display_ctrl.sv
// Multi-channel seven-segment debug readout, hex or double-dabble decimal.
// Define SEG_LEADING_ZERO_BLANK_EN to blank leading decimal zeros.
module seg_display_ctrl
   import seg_pkg::*;
#(
   parameter int DATA_W          = 16,
   parameter int DIGITS          = 4,
   parameter int CHANNELS        = 4,
   parameter int DEBOUNCE_CYCLES = 500_000,
   parameter int REFRESH_CYCLES  = 2_500_000,
   localparam int SEL_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic [CHANNELS*DATA_W-1:0] ch_data,
   input  logic                       next_btn_n,
   input  logic                       mode_dec,
   output logic [DIGITS*7-1:0]        seg,
   output logic [SEL_W-1:0]           ch_sel,
   output logic                       busy,
   output logic                       overflow
);

   localparam int BCD_N  = bcd_digits(DATA_W);
   localparam int BCD_W  = 4 * BCD_N;
   localparam int SH_W   = BCD_W + DATA_W;
   localparam int HEX_N  = (DATA_W + 3) / 4;
   localparam int DEC_W  = 4 * ((BCD_N > DIGITS) ? BCD_N : DIGITS);
   localparam int HEX_W  = 4 * ((HEX_N > DIGITS) ? HEX_N : DIGITS);
   localparam int IT_W   = (DATA_W > 1) ? $clog2(DATA_W) : 1;
   localparam int REF_W  =
      (REFRESH_CYCLES > 1) ? $clog2(REFRESH_CYCLES) : 1;

   localparam logic [IT_W-1:0]  IT_LAST  = IT_W'(DATA_W - 1);
   localparam logic [REF_W-1:0] REF_LAST = REF_W'(REFRESH_CYCLES - 1);
   localparam logic [SEL_W-1:0] SEL_LAST = SEL_W'(CHANNELS - 1);

   state_t              state_q;
   state_t              state_d;
   logic                take;
   logic                press;
   logic                ref_wrap;
   logic                pending_q;
   logic [REF_W-1:0]    ref_cnt_q;
   logic [SEL_W-1:0]    sel_q;
   logic                mode_q;
   logic [SH_W-1:0]     shreg_q;
   logic [IT_W-1:0]     iter_q;
   logic [DIGITS*7-1:0] seg_q;
   logic [DIGITS*7-1:0] seg_d;
   logic                ovf_q;
   logic                ovf_d;
   logic [DEC_W-1:0]    dec_pad;
   logic [HEX_W-1:0]    hex_pad;
   logic [DATA_W-1:0]   ch_word [CHANNELS];
`ifdef SEG_LEADING_ZERO_BLANK_EN
   logic                lead;
`endif

   for (genvar k = 0; k < CHANNELS; k++) begin : g_ch
      assign ch_word[k] = ch_data[k*DATA_W +: DATA_W];
   end

   btn_debouncer #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
   ) u_btn (
      .clk   (clk),
      .reset (reset),
      .btn_n (next_btn_n),
      .press (press)
   );

   // One double-dabble iteration: add-3 correction, then shift.
   function automatic logic [SH_W-1:0] dd_step(
      input logic [SH_W-1:0] s
   );
      logic [SH_W-1:0] t;
      t = s;
      for (int i = 0; i < BCD_N; i++) begin
         if (t[DATA_W+4*i +: 4] >= 4'd5)
            t[DATA_W+4*i +: 4] = t[DATA_W+4*i +: 4] + 4'd3;
      end
      return t << 1;
   endfunction

   assign ref_wrap = (ref_cnt_q == REF_LAST);
   assign dec_pad  = DEC_W'(shreg_q[SH_W-1 -: BCD_W]);
   assign hex_pad  = HEX_W'(shreg_q[DATA_W-1:0]);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state_q <= IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      take    = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (pending_q) begin
               take    = 1'b1;
               state_d = mode_dec ? CONV : DONE;
            end
         end
         CONV: begin
            if (iter_q == IT_LAST) state_d = DONE;
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      seg_d = '1;
      ovf_d = 1'b0;
`ifdef SEG_LEADING_ZERO_BLANK_EN
      lead  = 1'b1;
`endif
      unique case (1'b1)
         mode_q: begin
            ovf_d = |(dec_pad >> (4 * DIGITS));
            for (int d = 0; d < DIGITS; d++)
               seg_d[7*d +: 7] = hex_glyph(dec_pad[4*d +: 4]);
`ifdef SEG_LEADING_ZERO_BLANK_EN
            for (int d = DIGITS - 1; d > 0; d--) begin
               if (dec_pad[4*d +: 4] != 4'd0) lead = 1'b0;
               if (lead) seg_d[7*d +: 7] = SEG_BLANK;
            end
`endif
         end
         !mode_q: begin
            ovf_d = |(hex_pad >> (4 * DIGITS));
            for (int d = 0; d < DIGITS; d++)
               seg_d[7*d +: 7] = hex_glyph(hex_pad[4*d +: 4]);
         end
         default: ;
      endcase
      if (ovf_d) seg_d = {DIGITS{SEG_DASH}};
   end

   // A new request wins over the clear so merged requests are never lost.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         pending_q <= 1'b1;
         ref_cnt_q <= '0;
         sel_q     <= '0;
         mode_q    <= 1'b0;
         shreg_q   <= '0;
         iter_q    <= '0;
         seg_q     <= '1;
         ovf_q     <= 1'b0;
      end else begin
         pending_q <= (pending_q & ~take) | press | ref_wrap;
         ref_cnt_q <= (press | ref_wrap) ? '0 : ref_cnt_q + 1'b1;
         if (press)
            sel_q <= (sel_q == SEL_LAST) ? '0 : sel_q + 1'b1;
         if (take) begin
            mode_q  <= mode_dec;
            shreg_q <= SH_W'(ch_word[sel_q]);
            iter_q  <= '0;
         end else if (state_q == CONV) begin
            shreg_q <= dd_step(shreg_q);
            iter_q  <= iter_q + 1'b1;
         end
         if (state_q == DONE) begin
            seg_q <= seg_d;
            ovf_q <= ovf_d;
         end
      end
   end

   assign seg      = seg_q;
   assign overflow = ovf_q;
   assign ch_sel   = sel_q;
   assign busy     = (state_q == CONV);

endmodule

// File: tb/tb_seg_display_ctrl.sv
// Bench for seg_display_ctrl: directed literals plus random traffic
// checked every cycle against a behavioural display model.
module tb_seg_display_ctrl;

   localparam int DW  = 16;
   localparam int DG  = 4;
   localparam int CH  = 4;
   localparam int DEB = 4;
   localparam int REF = 64;

   logic             clk = 1'b0;
   logic             reset = 1'b0;
   logic [CH*DW-1:0] ch_data = '0;
   logic             btn_n = 1'b1;
   logic             mode_dec = 1'b0;
   logic [DG*7-1:0]  seg;
   logic [1:0]       ch_sel;
   logic             busy;
   logic             overflow;

   int checks = 0;
   int failures = 0;
   bit chk_en = 1'b0;

   always #5 clk = ~clk;

   seg_display_ctrl #(
      .DATA_W          (DW),
      .DIGITS          (DG),
      .CHANNELS        (CH),
      .DEBOUNCE_CYCLES (DEB),
      .REFRESH_CYCLES  (REF)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .ch_data    (ch_data),
      .next_btn_n (btn_n),
      .mode_dec   (mode_dec),
      .seg        (seg),
      .ch_sel     (ch_sel),
      .busy       (busy),
      .overflow   (overflow)
   );

   task automatic chk(input string name, input logic [31:0] got,
                      input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%h exp=%h t=%0t", name, got, exp, $time);
      end
   endtask

   function automatic logic [6:0] glyph(input int n);
      logic [6:0] ah;
      case (n)
         0: ah = 7'h3F;  1: ah = 7'h06;  2: ah = 7'h5B;  3: ah = 7'h4F;
         4: ah = 7'h66;  5: ah = 7'h6D;  6: ah = 7'h7D;  7: ah = 7'h07;
         8: ah = 7'h7F;  9: ah = 7'h6F; 10: ah = 7'h77; 11: ah = 7'h7C;
        12: ah = 7'h39; 13: ah = 7'h5E; 14: ah = 7'h79; default: ah = 7'h71;
      endcase
      return ~ah;
   endfunction

   function automatic void disp(input int v, input bit m,
                                output logic [DG*7-1:0] s, output bit o);
      int p;
      p = 1;
      s = '1;
      o = m ? (v >= 10**DG) : (v >= (1 << (4*DG)));
      for (int d = 0; d < DG; d++) begin
         if (m) begin
            s[7*d +: 7] = glyph((v / p) % 10);
`ifdef SEG_LEADING_ZERO_BLANK_EN
            if (d > 0 && v < p) s[7*d +: 7] = 7'h7F;
`endif
         end else begin
            s[7*d +: 7] = glyph((v >> (4*d)) & 15);
         end
         p = p * 10;
      end
      if (o) s = {DG{7'h3F}};
   endfunction

   // Behavioural model state
   bit              m_s1 = 1, m_s2 = 1, m_lvl = 1, m_pend = 1, m_idle = 1;
   bit              m_mode = 0, e_ovf = 0;
   int              m_run = 0, m_rc = 0, m_sel = 0, m_left = 0, m_snap = 0;
   logic [DG*7-1:0] e_seg = '1;

   always @(posedge clk or negedge reset) begin
      if (!reset) begin
         m_s1 = 1; m_s2 = 1; m_lvl = 1; m_run = 0;
         m_pend = 1; m_idle = 1; m_rc = 0; m_sel = 0;
         m_left = 0; m_mode = 0; e_seg = '1; e_ovf = 0;
      end else begin
         bit press, take, wrap;
         press = 0;
         take = 0;
         if (m_s2 != m_lvl) begin
            m_run++;
            if (m_run == DEB) begin
               m_lvl = m_s2;
               m_run = 0;
               press = !m_lvl;
            end
         end else begin
            m_run = 0;
         end
         m_s2 = m_s1;
         m_s1 = btn_n;
         if (m_idle) begin
            if (m_pend) begin
               take = 1;
               m_snap = int'(ch_data[m_sel*DW +: DW]);
               m_mode = mode_dec;
               m_left = mode_dec ? DW + 1 : 1;
               m_idle = 0;
            end
         end else begin
            m_left--;
            if (m_left == 0) begin
               disp(m_snap, m_mode, e_seg, e_ovf);
               m_idle = 1;
            end
         end
         wrap = (m_rc == REF - 1);
         m_rc = (press || wrap) ? 0 : m_rc + 1;
         m_pend = (m_pend && !take) || press || wrap;
         if (press) m_sel = (m_sel == CH - 1) ? 0 : m_sel + 1;
      end
   end

   always @(negedge clk) begin
      if (chk_en) begin
         chk("seg", 32'(seg), 32'(e_seg));
         chk("ch_sel", 32'(ch_sel), 32'(m_sel));
         chk("busy", 32'(busy), 32'(!m_idle && m_mode && m_left >= 2));
         chk("overflow", 32'(overflow), 32'(e_ovf));
      end
   end

   task automatic do_reset();
      @(negedge clk);
      #2 reset = 1'b0;
      @(negedge clk);
      @(negedge clk);
      reset = 1'b1;
   endtask

   task automatic set_ch(input int k, input int v);
      ch_data[k*DW +: DW] = DW'(v);
   endtask

   initial begin
      bit seen;
      int hold;
      set_ch(0, 16'h1A2F);
      set_ch(1, 16'h00B5);
      set_ch(2, 16'hC3D0);
      set_ch(3, 16'h7E69);
      @(posedge clk);
      chk_en = 1'b1;
      @(negedge clk);
      @(negedge clk);
      reset = 1'b1;

      // Hex snapshot right after reset
      @(posedge clk); #1;
      chk("hex_lat1_blank", 32'(seg), 32'h0FFF_FFFF);
      @(posedge clk); #1;
      chk("hex_1a2f", 32'(seg), 32'({7'h79, 7'h08, 7'h24, 7'h0E}));
      chk("hex_busy", 32'(busy), 32'd0);

      // Decimal 9876
      set_ch(0, 9876);
      mode_dec = 1'b1;
      do_reset();
      @(posedge clk); #1;
      chk("dec_busy_first", 32'(busy), 32'd1);
      repeat (15) @(posedge clk);
      #1 chk("dec_busy_last", 32'(busy), 32'd1);
      @(posedge clk); #1;
      chk("dec_busy_drop", 32'(busy), 32'd0);
      chk("dec_not_yet", 32'(seg), 32'h0FFF_FFFF);
      @(posedge clk); #1;
      chk("dec_9876", 32'(seg), 32'({7'h10, 7'h00, 7'h78, 7'h02}));
      chk("dec_9876_ovf", 32'(overflow), 32'd0);

      // Decimal overflow
      set_ch(0, 65535);
      do_reset();
      repeat (18) @(posedge clk);
      #1 chk("dec_ovf_dash", 32'(seg), 32'({7'h3F, 7'h3F, 7'h3F, 7'h3F}));
      chk("dec_ovf_flag", 32'(overflow), 32'd1);

      // Glitch then four clean presses, hex mode
      mode_dec = 1'b0;
      set_ch(0, 16'h1A2F);
      do_reset();
      repeat (4) @(negedge clk);
      btn_n = 1'b0;
      repeat (2) @(negedge clk);
      btn_n = 1'b1;
      repeat (10) @(negedge clk);
      chk("glitch_sel", 32'(ch_sel), 32'd0);
      for (int k = 1; k <= 4; k++) begin
         btn_n = 1'b0;
         repeat (8) @(negedge clk);
         btn_n = 1'b1;
         repeat (8) @(negedge clk);
         chk("press_sel", 32'(ch_sel), 32'(k % 4));
         if (k == 1)
            chk("hex_00b5", 32'(seg), 32'({7'h40, 7'h40, 7'h03, 7'h12}));
      end

      // Press during a conversion is served afterwards
      set_ch(0, 1234);
      set_ch(1, 42);
      mode_dec = 1'b1;
      do_reset();
      @(posedge clk);
      @(posedge clk);
      @(negedge clk);
      btn_n = 1'b0;
      repeat (8) @(negedge clk);
      btn_n = 1'b1;
      repeat (8) @(posedge clk);
      #1 chk("conv_1234", 32'(seg), 32'({7'h79, 7'h24, 7'h30, 7'h19}));
      repeat (18) @(posedge clk);
`ifdef SEG_LEADING_ZERO_BLANK_EN
      #1 chk("conv_42", 32'(seg), 32'({7'h7F, 7'h7F, 7'h19, 7'h24}));
`else
      #1 chk("conv_42", 32'(seg), 32'({7'h40, 7'h40, 7'h19, 7'h24}));
`endif
      chk("conv_42_sel", 32'(ch_sel), 32'd1);

      // Reset five cycles into a conversion
      set_ch(2, 5555);
      @(negedge clk);
      btn_n = 1'b0;
      seen = 1'b0;
      for (int i = 0; i < 60 && !seen; i++) begin
         @(posedge clk); #1;
         seen = busy;
      end
      if (!seen) chk("busy_start timeout", 32'd0, 32'd1);
      btn_n = 1'b1;
      repeat (4) @(posedge clk);
      #1 chk("pre_rst_sel", 32'(ch_sel), 32'd2);
      chk("pre_rst_busy", 32'(busy), 32'd1);
      @(negedge clk);
      #2 reset = 1'b0;
      #1 chk("rst_seg", 32'(seg), 32'h0FFF_FFFF);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_sel", 32'(ch_sel), 32'd0);
      chk("rst_ovf", 32'(overflow), 32'd0);
      @(negedge clk);
      reset = 1'b1;
      @(posedge clk); #1;
      chk("rst_restart", 32'(busy), 32'd1);

      // Random traffic
      hold = 3;
      for (int cyc = 0; cyc < 3000; cyc++) begin
         @(negedge clk);
         if ($urandom_range(0, 7) == 0) begin
            int k;
            int v;
            k = $urandom_range(0, CH - 1);
            v = ($urandom_range(0, 2) == 0) ?
                $urandom_range(0, 99) : $urandom_range(0, 65535);
            set_ch(k, v);
         end
         if ($urandom_range(0, 19) == 0) mode_dec = ~mode_dec;
         if (hold == 0) begin
            btn_n = ~btn_n;
            hold = $urandom_range(1, 10);
         end
         hold--;
      end
      btn_n = 1'b1;
      repeat (30) @(negedge clk);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/seg_display_ctrl.md
Name: seg_display_ctrl

Overview:
- Parametrised successor to the fixed four-digit hex readout used on the board wrapper.
- Displays one of CHANNELS debug words on DIGITS active-low 7-segment digits, in hex or unsigned decimal.
- A debounced push-button selects the channel.
- Sits between the CPU debug outputs and the board seven-segment pins.
- Decimal mode uses an iterative double-dabble converter.

Parameters:
- DATA_W, 16: width of each channel word.
- DIGITS, 4: number of 7-segment digits driven.
- CHANNELS, 4: number of selectable input words, minimum 1.
- DEBOUNCE_CYCLES, 500_000: cycles the button must be stable before it is accepted.
- REFRESH_CYCLES, 2_500_000: period of the automatic snapshot of the selected channel.

Ports:
- clk  in  1: system clock (50 MHz on board).
- reset  in  1: asynchronous, active-low reset.
- ch_data  in  CHANNELS*DATA_W: packed channel words; channel k is at [k*DATA_W +: DATA_W].
- next_btn_n  in  1: raw board key, active-low, asynchronous to clk.
- mode_dec  in  1: 0 = hex, 1 = unsigned decimal; sampled at snapshot.
- seg  out  DIGITS*7: digit d is at [d*7 +: 7]; bit order gfedcba; active-low; digit 0 is least significant.
- ch_sel  out  max(1,$clog2(CHANNELS)): currently selected channel.
- busy  out  1: decimal conversion in progress.
- overflow  out  1: the last snapshot value does not fit in DIGITS digits.

Behaviour:
- Reset (asynchronous, active-low):
  - seg all 1s (blank); ch_sel = 0; busy = 0; overflow = 0.
  - Debounce and refresh counters cleared.
  - A snapshot request is pending, so the first snapshot occurs in the first cycle after reset deasserts.
- Button:
  - 2-FF synchroniser, then a stability counter.
  - The debounced level changes only after DEBOUNCE_CYCLES consecutive equal synchronised samples.
  - A 1→0 transition of the debounced level is a press.
  - A press sets ch_sel ← (ch_sel == CHANNELS-1) ? 0 : ch_sel+1, sets a pending snapshot, and restarts the refresh counter.
- Refresh counter:
  - Counts 0..REFRESH_CYCLES-1 and wraps.
  - Sets a pending snapshot at the wrap.
- FSM states: IDLE, CONV, DONE.
- IDLE with pending snapshot:
  - Latch snap ← ch_data[ch_sel], latch mode ← mode_dec, clear pending.
  - Hex mode: go to DONE next cycle.
  - Decimal mode: load the shift register, go to CONV, busy = 1.
- CONV:
  - Exactly DATA_W iterations, one per cycle.
  - Each iteration adds 3 to every BCD nibble ≥ 5, then shifts left one bit.
  - BCD width = 4*ceil(DATA_W*0.30103 + 1).
- DONE (one cycle):
  - seg and overflow update atomically; busy = 0; return to IDLE.
- Latency from snapshot to seg update: hex 2 cycles; decimal DATA_W + 2 cycles.
- Hex encoding: standard 0–F glyphs.
  - overflow = 1 when DATA_W > 4*DIGITS and any bit above 4*DIGITS-1 is nonzero.
- Decimal:
  - overflow = 1 when any BCD nibble at index ≥ DIGITS is nonzero.
- When overflow = 1, every digit shows a dash (7'b0111111).
- Hex digits above the data width show 0.
- Simultaneous events:
  - Press and refresh wrap in the same cycle produce one pending snapshot.
  - Requests during CONV/DONE stay pending and are served on return to IDLE; multiple requests merge.
  - A channel change during CONV does not abort the conversion; the old value is displayed first, then the new snapshot follows.
- ch_data and mode_dec changes are ignored between snapshots; seg holds steady.
- Reset asserted mid-conversion aborts immediately to the reset values.

Optional Feature:
- Macro: SEG_LEADING_ZERO_BLANK_EN.
- Defined: leading zero digits in decimal mode are blanked (all 1s); digit 0 is always shown, so a value of 0 displays "   0".
- Hex mode is unaffected.
- Undefined: all digits are shown, zero-padded.

Decomposition:
- Shared package seg_pkg:
  - FSM state enum (IDLE/CONV/DONE).
  - SEG_BLANK = 7'h7F and SEG_DASH = 7'h3F.
  - 16-entry hex glyph constant table.
  - Function computing the BCD digit count from DATA_W.
- Sub-module btn_debouncer: synchroniser, stability counter, and one-cycle press pulse output; parametrised by DEBOUNCE_CYCLES.

Test Plan:
- Run with DEBOUNCE_CYCLES=4, REFRESH_CYCLES=64.
  - Reset, ch_data channel 0 = 16'h1A2F, mode_dec = 0 → seg = {1,A,2,F} glyphs 2 cycles after reset release; busy stays 0.
- mode_dec = 1, channel 0 = 16'd9876 → busy for 16 cycles, then digits 9,8,7,6; overflow = 0.
- Decimal, 16'd65535, DIGITS = 4 → all four digits show SEG_DASH; overflow = 1.
- Button glitch of 2 cycles → no ch_sel change.
  - Four clean presses (each held ≥ 6 cycles) → ch_sel 1,2,3,0; seg follows each channel's value.
- Press during CONV of 16'd1234 with channel 1 = 16'd42 → 1234 displays, then 0042 (or "  42" with SEG_LEADING_ZERO_BLANK_EN) without a dropped request.
- Assert reset 5 cycles into CONV → seg blank, busy = 0, ch_sel = 0 immediately; after release, a new conversion starts.
